// File: rtl/armleobus_arbiter2.sv
// Two-port round-robin arbiter for ArmleoBus.
// Routes one of two upstream requesters (s0, s1) onto a single downstream
// port (m) for the full length of a burst, then returns to IDLE for one
// arbitration cycle before the next grant.
//
// Ports:
//   clk, rst_n                      clock; asynchronous active-high reset
//   sN_transaction/cmd/address/     upstream request, held until done
//   burstcount/wdata/wbyte_enable
//   sN_transaction_done/response    per-beat completion back to requester
//   sN_rdata                        read data (valid only with own done)
//   m_transaction/cmd/address/      downstream request from granted port
//   burstcount/wdata/wbyte_enable
//   m_transaction_done/response/    downstream completion
//   rdata
module armleobus_arbiter2 #(
  parameter int unsigned ADDR_WIDTH = 34
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  s0_transaction,
  input  logic [2:0]            s0_cmd,
  input  logic [ADDR_WIDTH-1:0] s0_address,
  input  logic [3:0]            s0_burstcount,
  input  logic [31:0]           s0_wdata,
  input  logic [3:0]            s0_wbyte_enable,
  output logic                  s0_transaction_done,
  output logic [2:0]            s0_transaction_response,
  output logic [31:0]           s0_rdata,

  input  logic                  s1_transaction,
  input  logic [2:0]            s1_cmd,
  input  logic [ADDR_WIDTH-1:0] s1_address,
  input  logic [3:0]            s1_burstcount,
  input  logic [31:0]           s1_wdata,
  input  logic [3:0]            s1_wbyte_enable,
  output logic                  s1_transaction_done,
  output logic [2:0]            s1_transaction_response,
  output logic [31:0]           s1_rdata,

  output logic                  m_transaction,
  output logic [2:0]            m_cmd,
  output logic [ADDR_WIDTH-1:0] m_address,
  output logic [3:0]            m_burstcount,
  output logic [31:0]           m_wdata,
  output logic [3:0]            m_wbyte_enable,
  input  logic                  m_transaction_done,
  input  logic [2:0]            m_transaction_response,
  input  logic [31:0]           m_rdata
);

  // Downstream "beat completed successfully" response code.
  localparam logic [2:0] TRANSACTION_DONE = 3'd0;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic       grant_sel_q, grant_sel_d;
  logic       last_sel_q, last_sel_d;
  logic [3:0] beats_left_q, beats_left_d;

  // Arbitration helpers used only in IDLE.
  logic       pick_sel;
  logic [3:0] pick_burstcount;

  // Read data is broadcast; each requester qualifies it with its own done.
  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;

  // State register. last_sel resets to 1 so port 0 wins the first contention.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= IDLE;
      grant_sel_q  <= 1'b0;
      last_sel_q   <= 1'b1;
      beats_left_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      grant_sel_q  <= grant_sel_d;
      last_sel_q   <= last_sel_d;
      beats_left_q <= beats_left_d;
    end
  end

  // Next-state, arbitration and output routing.
  always_comb begin
    state_d                 = state_q;
    grant_sel_d             = grant_sel_q;
    last_sel_d              = last_sel_q;
    beats_left_d            = beats_left_q;
    pick_sel                = 1'b0;
    pick_burstcount         = 4'd0;

    m_transaction           = 1'b0;
    m_cmd                   = 3'd0;
    m_address               = '0;
    m_burstcount            = 4'd0;
    m_wdata                 = 32'd0;
    m_wbyte_enable          = 4'd0;
    s0_transaction_done     = 1'b0;
    s0_transaction_response = 3'd0;
    s1_transaction_done     = 1'b0;
    s1_transaction_response = 3'd0;

    case (state_q)
      IDLE: begin
        // On contention, serve the port that did not win last time.
        if (s0_transaction && s1_transaction) begin
          pick_sel = ~last_sel_q;
        end else begin
          pick_sel = s1_transaction;
        end
        pick_burstcount = pick_sel ? s1_burstcount : s0_burstcount;

        if (s0_transaction || s1_transaction) begin
          state_d      = GRANTED;
          grant_sel_d  = pick_sel;
          beats_left_d = (pick_burstcount == 4'd0) ? 4'd1 : pick_burstcount;
        end
      end

      GRANTED: begin
        if (grant_sel_q) begin
          m_transaction           = s1_transaction;
          m_cmd                   = s1_cmd;
          m_address               = s1_address;
          m_burstcount            = s1_burstcount;
          m_wdata                 = s1_wdata;
          m_wbyte_enable          = s1_wbyte_enable;
          s1_transaction_done     = m_transaction_done;
          s1_transaction_response = m_transaction_response;
        end else begin
          m_transaction           = s0_transaction;
          m_cmd                   = s0_cmd;
          m_address               = s0_address;
          m_burstcount            = s0_burstcount;
          m_wdata                 = s0_wdata;
          m_wbyte_enable          = s0_wbyte_enable;
          s0_transaction_done     = m_transaction_done;
          s0_transaction_response = m_transaction_response;
        end

        // Last beat or any error response ends the burst.
        if (m_transaction_done) begin
          beats_left_d = beats_left_q - 4'd1;
          if ((beats_left_q == 4'd1) ||
              (m_transaction_response != TRANSACTION_DONE)) begin
            state_d    = IDLE;
            last_sel_d = grant_sel_q;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_armleobus_arbiter2.sv
// Directed self-checking bench for armleobus_arbiter2.
module tb_armleobus_arbiter2;

  localparam int unsigned ADDR_WIDTH = 34;
  localparam logic [2:0] CMD_READ  = 3'd1;
  localparam logic [2:0] CMD_WRITE = 3'd2;
  localparam logic [2:0] RESP_DONE = 3'd0;
  localparam logic [2:0] RESP_UNKNOWN_ADDRESS = 3'd3;

  logic                  clk;
  logic                  rst_n;
  logic                  s0_transaction, s1_transaction;
  logic [2:0]            s0_cmd, s1_cmd;
  logic [ADDR_WIDTH-1:0] s0_address, s1_address;
  logic [3:0]            s0_burstcount, s1_burstcount;
  logic [31:0]           s0_wdata, s1_wdata;
  logic [3:0]            s0_wbyte_enable, s1_wbyte_enable;
  logic                  s0_transaction_done, s1_transaction_done;
  logic [2:0]            s0_transaction_response, s1_transaction_response;
  logic [31:0]           s0_rdata, s1_rdata;
  logic                  m_transaction;
  logic [2:0]            m_cmd;
  logic [ADDR_WIDTH-1:0] m_address;
  logic [3:0]            m_burstcount;
  logic [31:0]           m_wdata;
  logic [3:0]            m_wbyte_enable;
  logic                  m_transaction_done;
  logic [2:0]            m_transaction_response;
  logic [31:0]           m_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  armleobus_arbiter2 #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .s0_transaction          (s0_transaction),
    .s0_cmd                  (s0_cmd),
    .s0_address              (s0_address),
    .s0_burstcount           (s0_burstcount),
    .s0_wdata                (s0_wdata),
    .s0_wbyte_enable         (s0_wbyte_enable),
    .s0_transaction_done     (s0_transaction_done),
    .s0_transaction_response (s0_transaction_response),
    .s0_rdata                (s0_rdata),
    .s1_transaction          (s1_transaction),
    .s1_cmd                  (s1_cmd),
    .s1_address              (s1_address),
    .s1_burstcount           (s1_burstcount),
    .s1_wdata                (s1_wdata),
    .s1_wbyte_enable         (s1_wbyte_enable),
    .s1_transaction_done     (s1_transaction_done),
    .s1_transaction_response (s1_transaction_response),
    .s1_rdata                (s1_rdata),
    .m_transaction           (m_transaction),
    .m_cmd                   (m_cmd),
    .m_address               (m_address),
    .m_burstcount            (m_burstcount),
    .m_wdata                 (m_wdata),
    .m_wbyte_enable          (m_wbyte_enable),
    .m_transaction_done      (m_transaction_done),
    .m_transaction_response  (m_transaction_response),
    .m_rdata                 (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    s0_transaction = 1'b0; s0_cmd = 3'd0; s0_address = '0; s0_burstcount = 4'd0;
    s0_wdata = 32'd0; s0_wbyte_enable = 4'd0;
    s1_transaction = 1'b0; s1_cmd = 3'd0; s1_address = '0; s1_burstcount = 4'd0;
    s1_wdata = 32'd0; s1_wbyte_enable = 4'd0;
    m_transaction_done = 1'b0; m_transaction_response = RESP_DONE; m_rdata = 32'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    clear_inputs();
    #1;
    // Reset state: all downstream outputs idle.
    s0_transaction = 1'b1; s0_cmd = CMD_READ; s0_address = 34'h40;
    settle();
    check_eq("reset_m_transaction", 64'(m_transaction), 64'd0);
    check_eq("reset_m_cmd", 64'(m_cmd), 64'd0);
    check_eq("reset_m_address", 64'(m_address), 64'd0);
    check_eq("reset_s0_done", 64'(s0_transaction_done), 64'd0);
    do_reset();

    // s0 single read.
    s0_transaction = 1'b1; s0_cmd = CMD_READ; s0_address = 34'h40; s0_burstcount = 4'd1;
    settle();
    check_eq("rd_idle_m_transaction", 64'(m_transaction), 64'd0);
    check_eq("rd_idle_m_cmd", 64'(m_cmd), 64'd0);
    tick();
    settle();
    check_eq("rd_grant_m_transaction", 64'(m_transaction), 64'd1);
    check_eq("rd_grant_m_address", 64'(m_address), 64'h40);
    check_eq("rd_grant_m_cmd", 64'(m_cmd), 64'(CMD_READ));
    m_transaction_done = 1'b1; m_rdata = 32'h1;
    settle();
    check_eq("rd_s0_done", 64'(s0_transaction_done), 64'd1);
    check_eq("rd_s0_rdata", 64'(s0_rdata), 64'h1);
    check_eq("rd_s1_done", 64'(s1_transaction_done), 64'd0);
    check_eq("rd_s1_rdata_bcast", 64'(s1_rdata), 64'h1);
    tick();
    clear_inputs();
    settle();
    check_eq("rd_back_idle", 64'(m_transaction), 64'd0);

    // Contention right after reset: s0, bubble, s1, bubble, s0.
    do_reset();
    s0_transaction = 1'b1; s0_cmd = CMD_READ; s0_address = 34'h100; s0_burstcount = 4'd1;
    s1_transaction = 1'b1; s1_cmd = CMD_READ; s1_address = 34'h200; s1_burstcount = 4'd1;
    tick();
    settle();
    check_eq("rr_first_addr", 64'(m_address), 64'h100);
    m_transaction_done = 1'b1;
    settle();
    check_eq("rr_first_s0_done", 64'(s0_transaction_done), 64'd1);
    check_eq("rr_first_s1_done", 64'(s1_transaction_done), 64'd0);
    tick();
    m_transaction_done = 1'b0;
    settle();
    check_eq("rr_bubble1", 64'(m_transaction), 64'd0);
    tick();
    settle();
    check_eq("rr_second_addr", 64'(m_address), 64'h200);
    m_transaction_done = 1'b1;
    settle();
    check_eq("rr_second_s1_done", 64'(s1_transaction_done), 64'd1);
    check_eq("rr_second_s0_done", 64'(s0_transaction_done), 64'd0);
    tick();
    m_transaction_done = 1'b0;
    settle();
    check_eq("rr_bubble2", 64'(m_transaction), 64'd0);
    tick();
    settle();
    check_eq("rr_third_addr", 64'(m_address), 64'h100);
    m_transaction_done = 1'b1;
    tick();
    clear_inputs();

    // s1 burst of 4; s0 arrives at beat 2 and must wait.
    s1_transaction = 1'b1; s1_cmd = CMD_READ; s1_address = 34'h300; s1_burstcount = 4'd4;
    s0_address = 34'h3A0; s0_cmd = CMD_READ; s0_burstcount = 4'd1;
    tick();
    for (int beat = 1; beat <= 4; beat++) begin
      if (beat == 2) s0_transaction = 1'b1;
      m_transaction_done = 1'b1;
      settle();
      check_eq($sformatf("burst_beat%0d_addr", beat), 64'(m_address), 64'h300);
      check_eq($sformatf("burst_beat%0d_s1_done", beat), 64'(s1_transaction_done), 64'd1);
      check_eq($sformatf("burst_beat%0d_s0_done", beat), 64'(s0_transaction_done), 64'd0);
      tick();
    end
    m_transaction_done = 1'b0;
    s1_transaction = 1'b0;
    settle();
    check_eq("burst_end_idle", 64'(m_transaction), 64'd0);
    tick();
    settle();
    check_eq("burst_then_s0_addr", 64'(m_address), 64'h3A0);
    m_transaction_done = 1'b1;
    tick();
    clear_inputs();

    // Error on beat 2 of an s0 burst ends it early; s1 follows.
    do_reset();
    s0_transaction = 1'b1; s0_cmd = CMD_READ; s0_address = 34'h400; s0_burstcount = 4'd4;
    s1_transaction = 1'b1; s1_cmd = CMD_READ; s1_address = 34'h500; s1_burstcount = 4'd1;
    tick();
    settle();
    check_eq("err_grant_addr", 64'(m_address), 64'h400);
    m_transaction_done = 1'b1;
    tick();
    m_transaction_response = RESP_UNKNOWN_ADDRESS;
    settle();
    check_eq("err_s0_done", 64'(s0_transaction_done), 64'd1);
    check_eq("err_s0_resp", 64'(s0_transaction_response), 64'(RESP_UNKNOWN_ADDRESS));
    check_eq("err_s1_resp", 64'(s1_transaction_response), 64'd0);
    tick();
    m_transaction_done = 1'b0; m_transaction_response = RESP_DONE;
    s0_transaction = 1'b0;
    settle();
    check_eq("err_idle", 64'(m_transaction), 64'd0);
    tick();
    settle();
    check_eq("err_s1_granted", 64'(m_transaction), 64'd1);
    check_eq("err_s1_addr", 64'(m_address), 64'h500);
    m_transaction_done = 1'b1;
    tick();
    clear_inputs();

    // Write with burstcount 0 is a single beat.
    s0_transaction = 1'b1; s0_cmd = CMD_WRITE; s0_address = 34'h600;
    s0_wdata = 32'hFF; s0_wbyte_enable = 4'hF; s0_burstcount = 4'd0;
    tick();
    settle();
    check_eq("wr_m_cmd", 64'(m_cmd), 64'(CMD_WRITE));
    check_eq("wr_m_wdata", 64'(m_wdata), 64'hFF);
    check_eq("wr_m_wbe", 64'(m_wbyte_enable), 64'hF);
    check_eq("wr_m_burstcount", 64'(m_burstcount), 64'd0);
    m_transaction_done = 1'b1;
    settle();
    check_eq("wr_s0_done", 64'(s0_transaction_done), 64'd1);
    tick();
    m_transaction_done = 1'b0;
    settle();
    check_eq("wr_single_beat_idle", 64'(m_transaction), 64'd0);
    check_eq("wr_idle_wdata", 64'(m_wdata), 64'd0);
    clear_inputs();
    tick();

    // Reset in the middle of an s1 burst.
    s1_transaction = 1'b1; s1_cmd = CMD_READ; s1_address = 34'h700; s1_burstcount = 4'd4;
    tick();
    m_transaction_done = 1'b1;
    tick();
    settle();
    check_eq("rst_mid_before", 64'(m_transaction), 64'd1);
    rst_n = 1'b1;
    settle();
    check_eq("rst_mid_m_transaction", 64'(m_transaction), 64'd0);
    check_eq("rst_mid_s1_done", 64'(s1_transaction_done), 64'd0);
    check_eq("rst_mid_m_address", 64'(m_address), 64'd0);
    tick();
    m_transaction_done = 1'b0;
    rst_n = 1'b0;
    s0_transaction = 1'b1; s0_cmd = CMD_READ; s0_address = 34'h800; s0_burstcount = 4'd1;
    settle();
    check_eq("rst_rel_idle", 64'(m_transaction), 64'd0);
    tick();
    settle();
    check_eq("rst_rel_s0_wins", 64'(m_address), 64'h800);
    m_transaction_done = 1'b1;
    settle();
    check_eq("rst_rel_s0_done", 64'(s0_transaction_done), 64'd1);
    tick();
    clear_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
